// File: rtl/vga_pattern_sequencer.sv
// Per-frame scroll and pattern sequencer for the VGA colour datapath.
// Register writes land in shadow copies and take effect only in the frame-boundary APPLY/STEP sequence.
module vga_pattern_sequencer #(
  parameter int H_WRAP    = 640,
  parameter int V_WRAP    = 480,
  parameter int DWELL_RST = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [9:0] scroll_x,
  output logic [9:0] scroll_y,
  output logic [1:0] pattern_sel,
  output logic [7:0] frame_count,
  output logic       frame_tick
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] APPLY = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;

  localparam logic [7:0]  DWELL_INIT = 8'(DWELL_RST);
  localparam logic [10:0] H_LIM      = 11'(H_WRAP);
  localparam logic [10:0] V_LIM      = 11'(V_WRAP);

  logic [1:0] state;
  logic       vsync_q;

  logic       sh_auto, sh_scroll, clr_pend;
  logic [1:0] sh_pat;
  logic [3:0] sh_dx, sh_dy;
  logic [7:0] sh_dwell;

  logic       act_auto, act_scroll, clr_cap;
  logic [1:0] act_pat;
  logic [3:0] act_dx, act_dy;
  logic [7:0] act_dwell;
  logic [7:0] dwell_cnt;

  logic        frame_start;
  logic [10:0] sum_x, sum_y, wrap_x, wrap_y;
  logic [7:0]  dwell_lim;

  assign cfg_ready   = (state == IDLE);
  assign frame_start = vsync & ~vsync_q;

  // Increments never exceed one modulus, so a single conditional subtract wraps them.
  assign sum_x  = {1'b0, scroll_x} + {7'd0, act_dx};
  assign sum_y  = {1'b0, scroll_y} + {7'd0, act_dy};
  assign wrap_x = (sum_x >= H_LIM) ? (sum_x - H_LIM) : sum_x;
  assign wrap_y = (sum_y >= V_LIM) ? (sum_y - V_LIM) : sum_y;

  // A dwell of zero behaves as one frame per pattern.
  assign dwell_lim = (act_dwell == 8'd0) ? 8'd0 : (act_dwell - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      sh_auto     <= 1'b0;
      sh_scroll   <= 1'b0;
      sh_pat      <= 2'd0;
      sh_dx       <= 4'd0;
      sh_dy       <= 4'd0;
      sh_dwell    <= DWELL_INIT;
      clr_pend    <= 1'b0;
      act_auto    <= 1'b0;
      act_scroll  <= 1'b0;
      act_pat     <= 2'd0;
      act_dx      <= 4'd0;
      act_dy      <= 4'd0;
      act_dwell   <= DWELL_INIT;
      clr_cap     <= 1'b0;
      dwell_cnt   <= 8'd0;
      scroll_x    <= 10'd0;
      scroll_y    <= 10'd0;
      pattern_sel <= 2'd0;
      frame_count <= 8'd0;
      frame_tick  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            case (cfg_addr)
              2'd0: begin
                sh_auto   <= cfg_data[0];
                sh_scroll <= cfg_data[1];
                sh_pat    <= cfg_data[3:2];
              end
              2'd1: begin
                sh_dx <= cfg_data[3:0];
                sh_dy <= cfg_data[7:4];
              end
              2'd2: sh_dwell <= cfg_data;
              default: begin
                if (cfg_data[0]) clr_pend <= 1'b1;
              end
            endcase
          end
          if (frame_start) state <= APPLY;
        end
        APPLY: begin
          act_auto   <= sh_auto;
          act_scroll <= sh_scroll;
          act_pat    <= sh_pat;
          act_dx     <= sh_dx;
          act_dy     <= sh_dy;
          act_dwell  <= sh_dwell;
          clr_cap    <= clr_pend;
          clr_pend   <= 1'b0;
          state      <= STEP;
        end
        STEP: begin
          if (clr_cap) begin
            scroll_x <= 10'd0;
            scroll_y <= 10'd0;
          end else if (act_scroll) begin
            scroll_x <= wrap_x[9:0];
            scroll_y <= wrap_y[9:0];
          end
          // Manual mode parks the dwell counter so auto cycling restarts cleanly.
          if (act_auto) begin
            if (dwell_cnt >= dwell_lim) begin
              pattern_sel <= pattern_sel + 2'd1;
              dwell_cnt   <= 8'd0;
            end else begin
              dwell_cnt <= dwell_cnt + 8'd1;
            end
          end else begin
            pattern_sel <= act_pat;
            dwell_cnt   <= 8'd0;
          end
          frame_count <= frame_count + 8'd1;
          frame_tick  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer: per-cycle reference model compare plus
// directed literal checks on scrolling, wrapping, pattern cycling, handshake and reset.
module tb_vga_pattern_sequencer;

  localparam int H_WRAP    = 640;
  localparam int V_WRAP    = 480;
  localparam int DWELL_RST = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic [1:0] pattern_sel;
  logic [7:0] frame_count;
  logic       frame_tick;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .H_WRAP(H_WRAP),
    .V_WRAP(V_WRAP),
    .DWELL_RST(DWELL_RST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .scroll_x(scroll_x),
    .scroll_y(scroll_y),
    .pattern_sel(pattern_sel),
    .frame_count(frame_count),
    .frame_tick(frame_tick)
  );

  // Reference model: raw register bytes decoded arithmetically; phase counts cycles since frame start.
  int m_phase, m_prev_v;
  int s_ctrl, s_speed, s_dwell, a_ctrl, a_speed, a_dwell;
  bit s_clr, a_clr, m_tick;
  int m_x, m_y, m_pat, m_cnt, m_frames;

  task automatic model_step();
    int eff;
    if (a_clr) begin
      m_x = 0;
      m_y = 0;
    end else if ((a_ctrl / 2) % 2 == 1) begin
      m_x = (m_x + a_speed % 16) % H_WRAP;
      m_y = (m_y + a_speed / 16) % V_WRAP;
    end
    eff = (a_dwell == 0) ? 1 : a_dwell;
    if (a_ctrl % 2 == 1) begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= eff) begin
        m_pat = (m_pat + 1) % 4;
        m_cnt = 0;
      end
    end else begin
      m_pat = (a_ctrl / 4) % 4;
      m_cnt = 0;
    end
    m_frames = (m_frames + 1) % 256;
    m_tick   = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_prev_v = 0;
      s_ctrl = 0; s_speed = 0; s_dwell = DWELL_RST; s_clr = 1'b0;
      a_ctrl = 0; a_speed = 0; a_dwell = DWELL_RST; a_clr = 1'b0;
      m_x = 0; m_y = 0; m_pat = 0; m_cnt = 0; m_frames = 0; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (m_phase == 0) begin
        if (cfg_valid) begin
          case (cfg_addr)
            2'd0: s_ctrl = int'(cfg_data);
            2'd1: s_speed = int'(cfg_data);
            2'd2: s_dwell = int'(cfg_data);
            default: if (cfg_data[0]) s_clr = 1'b1;
          endcase
        end
        if (vsync && m_prev_v == 0) m_phase = 1;
      end else if (m_phase == 1) begin
        a_ctrl = s_ctrl; a_speed = s_speed; a_dwell = s_dwell;
        a_clr = s_clr; s_clr = 1'b0;
        m_phase = 2;
      end else begin
        model_step();
        m_phase = 0;
      end
      m_prev_v = vsync ? 1 : 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("scroll_x", 32'(scroll_x), 32'(m_x));
      check_output("scroll_y", 32'(scroll_y), 32'(m_y));
      check_output("pattern_sel", 32'(pattern_sel), 32'(m_pat));
      check_output("frame_count", 32'(frame_count), 32'(m_frames));
      check_output("frame_tick", 32'(frame_tick), 32'(m_tick));
      check_output("cfg_ready", 32'(cfg_ready), (m_phase == 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(4);
  endtask

  // Config write that holds the request until the handshake completes.
  task automatic apply_stimulus(input logic [1:0] addr, input logic [7:0] data);
    bit done = 1'b0;
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) done = 1'b1;
    end
    if (!done) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("[TB] FAIL cfg_accept: got no cfg_ready within 16 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pat_exp [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    rst_n = 1'b0; vsync = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    check_output("rst_scroll_x", 32'(scroll_x), 32'd0);
    check_output("rst_pattern", 32'(pattern_sel), 32'd0);
    check_output("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    check_output("ready_after_reset", 32'(cfg_ready), 32'd1);

    // Basic scrolling with the update three cycles after vsync is first seen high.
    apply_stimulus(2'd0, 8'h02);
    apply_stimulus(2'd1, 8'h21);
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    check_output("ready_in_apply", 32'(cfg_ready), 32'd0);
    tick(1);
    check_output("tick_before_update", 32'(frame_tick), 32'd0);
    check_output("x_before_update", 32'(scroll_x), 32'd0);
    tick(1);
    check_output("tick_on_update", 32'(frame_tick), 32'd1);
    check_output("x_frame1", 32'(scroll_x), 32'd1);
    check_output("y_frame1", 32'(scroll_y), 32'd2);
    tick(2);
    frame();
    check_output("x_frame2", 32'(scroll_x), 32'd2);
    check_output("y_frame2", 32'(scroll_y), 32'd4);
    frame();
    check_output("x_frame3", 32'(scroll_x), 32'd3);
    check_output("y_frame3", 32'(scroll_y), 32'd6);
    check_output("count_frame3", 32'(frame_count), 32'd3);

    // Walk to 636/478, then wrap both axes.
    apply_stimulus(2'd1, 8'h9C);
    apply_stimulus(2'd3, 8'h01);
    frame();
    check_output("x_cleared", 32'(scroll_x), 32'd0);
    repeat (53) frame();
    check_output("x_walk", 32'(scroll_x), 32'd636);
    check_output("y_walk", 32'(scroll_y), 32'd477);
    apply_stimulus(2'd1, 8'h10);
    frame();
    check_output("y_walk2", 32'(scroll_y), 32'd478);
    apply_stimulus(2'd1, 8'h35);
    frame();
    check_output("x_wrap", 32'(scroll_x), 32'd1);
    check_output("y_wrap", 32'(scroll_y), 32'd1);

    // Clear command suppresses that frame's increment.
    apply_stimulus(2'd1, 8'h04);
    apply_stimulus(2'd3, 8'h01);
    frame();
    check_output("x_clr", 32'(scroll_x), 32'd0);
    check_output("y_clr", 32'(scroll_y), 32'd0);
    frame();
    check_output("x_after_clr", 32'(scroll_x), 32'd4);

    // Auto cycling with DWELL=2, then DWELL=0.
    apply_stimulus(2'd0, 8'h01);
    apply_stimulus(2'd2, 8'h02);
    for (int i = 0; i < 8; i++) begin
      frame();
      check_output("auto_dwell2", 32'(pattern_sel), 32'(pat_exp[i]));
    end
    apply_stimulus(2'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      frame();
      check_output("auto_dwell0", 32'(pattern_sel), 32'(i + 1));
    end

    // Lowering DWELL below the running count advances at once.
    apply_stimulus(2'd2, 8'h04);
    repeat (3) frame();
    check_output("dwell4_hold", 32'(pattern_sel), 32'd3);
    apply_stimulus(2'd2, 8'h02);
    frame();
    check_output("dwell_lowered", 32'(pattern_sel), 32'd0);

    // Manual pattern, then auto resumes from it.
    apply_stimulus(2'd0, 8'h0C);
    frame();
    check_output("manual_pat", 32'(pattern_sel), 32'd3);
    apply_stimulus(2'd0, 8'h01);
    frame();
    check_output("auto_resume1", 32'(pattern_sel), 32'd3);
    frame();
    check_output("auto_resume2", 32'(pattern_sel), 32'd0);

    // Request held across APPLY/STEP is accepted in the following IDLE cycle.
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h0A;
    check_output("held_ready_apply", 32'(cfg_ready), 32'd0);
    tick(1);
    check_output("held_ready_step", 32'(cfg_ready), 32'd0);
    tick(1);
    check_output("held_ready_idle", 32'(cfg_ready), 32'd1);
    check_output("held_pat_old", 32'(pattern_sel), 32'd0);
    tick(1);
    cfg_valid = 1'b0;
    tick(2);
    check_output("held_pat_unchanged", 32'(pattern_sel), 32'd0);
    frame();
    check_output("held_pat_applied", 32'(pattern_sel), 32'd2);
    check_output("held_x_applied", 32'(scroll_x), 32'd8);

    // Reset during STEP.
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_output("midrst_x", 32'(scroll_x), 32'd0);
    check_output("midrst_pat", 32'(pattern_sel), 32'd0);
    check_output("midrst_count", 32'(frame_count), 32'd0);
    check_output("midrst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    check_output("midrst_ready", 32'(cfg_ready), 32'd1);

    // Default dwell of 60 frames, then frame_count wrap.
    apply_stimulus(2'd0, 8'h01);
    repeat (59) frame();
    check_output("dwell60_hold", 32'(pattern_sel), 32'd0);
    frame();
    check_output("dwell60_adv", 32'(pattern_sel), 32'd1);
    check_output("count_60", 32'(frame_count), 32'd60);
    repeat (196) frame();
    check_output("count_wrap", 32'(frame_count), 32'd0);

    tick(2);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

Interface
REQ-001 SHALL expose parameter H_WRAP, default 640, horizontal scroll modulus.
REQ-002 SHALL expose parameter V_WRAP, default 480, vertical scroll modulus.
REQ-003 SHALL expose parameter DWELL_RST, default 60, reset value of the frame-dwell register.
REQ-004 clk  in  1  pixel clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 vsync  in  1  registered, active-high vertical sync from the sync generator.
REQ-007 cfg_valid  in  1  config write request.
REQ-008 cfg_ready  out  1  config write accept.
REQ-009 cfg_addr  in  2  register select.
REQ-010 cfg_data  in  8  write data.
REQ-011 scroll_x  out  10  active horizontal offset, range 0..H_WRAP-1.
REQ-012 scroll_y  out  10  active vertical offset, range 0..V_WRAP-1.
REQ-013 pattern_sel  out  2  active pattern index for the colour datapath.
REQ-014 frame_count  out  8  frames processed, wraps 255->0.
REQ-015 frame_tick  out  1  one-cycle pulse when the active outputs update.

Function
REQ-016 Registers: addr0 CTRL {[0] auto_en, [1] scroll_en, [3:2] manual_pat}; addr1 SPEED {[3:0] dx, [7:4] dy}, unsigned; addr2 DWELL, frames per pattern, 0 treated as 1; addr3 CMD {[0] clr_scroll}, write-only.
REQ-017 A write SHALL be accepted on any cycle with cfg_valid=1 and cfg_ready=1; data goes to shadow copies only; last accepted write before APPLY wins.
REQ-018 frame_start SHALL be vsync=1 while the previous-cycle vsync sample is 0 (rising edge).
REQ-019 FSM states IDLE, APPLY, STEP; IDLE->APPLY on frame_start; APPLY->STEP unconditionally; STEP->IDLE unconditionally.
REQ-020 cfg_ready SHALL be 1 in IDLE and 0 in APPLY and STEP; a pending request is held off, not dropped.
REQ-021 frame_start while in APPLY or STEP SHALL be ignored.
REQ-022 APPLY: copy all shadows to active; capture and clear pending clr_scroll.
REQ-023 STEP with captured clr_scroll: scroll_x=scroll_y=0, no increment this frame.
REQ-024 STEP with scroll_en=1: scroll_x=(scroll_x+dx) mod H_WRAP, scroll_y=(scroll_y+dy) mod V_WRAP, via single conditional subtract; with scroll_en=0 offsets hold.
REQ-025 STEP auto_en=1: if dwell_cnt>=max(DWELL,1)-1 then pattern_sel+=1 mod 4 and dwell_cnt=0, else dwell_cnt+=1.
REQ-026 STEP auto_en=0: pattern_sel=manual_pat, dwell_cnt=0; on auto_en 0->1, cycling starts from current pattern_sel with dwell_cnt=0.
REQ-027 DWELL lowered below current dwell_cnt SHALL advance pattern at the next STEP.
REQ-028 STEP SHALL increment frame_count and assert frame_tick; outputs change on the clock edge leaving STEP, i.e. 3 cycles after the first cycle vsync is sampled high.
REQ-029 Outputs SHALL not change outside STEP.

Reset
REQ-030 rst_n=0 at any clock edge, including mid-APPLY/STEP: state=IDLE, scroll_x=scroll_y=0, pattern_sel=0, frame_count=0, frame_tick=0, dwell_cnt=0, vsync sample=0, all shadow and active registers 0 except DWELL=DWELL_RST, pending clr_scroll cleared.
REQ-031 cfg_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-032 CTRL=0x02, SPEED=0x21, 3 vsync pulses -> scroll_x 1,2,3 and scroll_y 2,4,6, each 3 cycles after vsync rise with frame_tick.
REQ-033 scroll_x=636 and scroll_y=478 via stepping, dx=5, dy=3 -> next frame scroll_x=1, scroll_y=1.
REQ-034 CTRL=0x01, DWELL=2, 8 frames -> pattern_sel 0,1,1,2,2,3,3,0; DWELL=0 -> advances every frame.
REQ-035 cfg_valid held high during APPLY/STEP -> cfg_ready=0 there, write accepted first IDLE cycle, effective next frame only.
REQ-036 CMD=0x01 with scroll_en=1, dx=4 -> next frame scroll_x=scroll_y=0, following frame scroll_x=4.
REQ-037 rst_n pulsed low in STEP -> all outputs at reset values next cycle, DWELL=60, cfg_ready=1 after release.
